pre_samp_mlane: RTL and testbench

- Parametrised successor of the SamplerZ pre-sampling setup stage. It reads one packed word of LANES centre values (mu) and one word of up to four 1/sigma values (isigma) from sampler memory.
- It converts the selected isigma from IEEE-754 double to unsigned 72-bit fixed point (value·2^72), then runs two products on a shared 81-bit multiplier pair through a request/grant handshake.
- It presents LANES raw mu values, sqr2_isigma and ccs_63 to the downstream sampler lanes.
- Unlike the previous generation, the following are all programmable or explicit: lane count, read latency, isigma slot, multiplier arbitration/latency, and an exponent-range error flag.

---
 rtl/pre_samp_mlane.sv | 183 ++++++++++++++++++
 tb/tb_pre_samp_mlane.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_samp_mlane.sv
// SamplerZ pre-sampling setup: fetches LANES mu values and one isigma double, converts
// isigma to 72-bit fixed point and forms sqr2_isigma / ccs_63 on a shared multiplier pair.
module pre_samp_mlane #(
   parameter int unsigned LANES          = 2,
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned READ_DELAY     = 2,
   parameter int unsigned MUL_LAT        = 1,
   parameter logic [72:0] MIN_SIGMA_512  = 73'h147201bf1f7a0000000,
   parameter logic [72:0] MIN_SIGMA_1024 = 73'h14c5c19990c80000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [ADDR_W-1:0]     mu_addr,
   input  logic [ADDR_W-1:0]     isigma_addr,
   input  logic [1:0]            isigma_sel,
   output logic                  busy,
   output logic                  r_en,
   output logic [ADDR_W-1:0]     r_addr,
   input  logic [255:0]          r_data,
   output logic                  mul_req,
   input  logic                  mul_gnt,
   output logic [80:0]           mul_a_l,
   output logic [80:0]           mul_b_l,
   output logic [80:0]           mul_a_r,
   output logic [80:0]           mul_b_r,
   input  logic                  mul_vld,
   input  logic [80:0]           mul_out_l,
   input  logic [80:0]           mul_out_r,
   output logic [64*LANES-1:0]   fpr_mu,
   output logic [71:0]           isigma,
   output logic [71:0]           sqr2_isigma,
   output logic [62:0]           ccs_63,
   output logic                  err,
   output logic                  done
);

   typedef enum logic [2:0] {
      StIdle, StRdMu, StRdSg, StWait, StConv, StMreq, StMwait, StDone
   } state_t;

   // r_data is registered on entry, so each latch point is one cycle after data is valid
   localparam logic [3:0] MuTap = 4'(READ_DELAY + 1);
   localparam logic [3:0] FsTap = 4'(READ_DELAY + 2);

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic                r_mode;
   logic [ADDR_W-1:0]   r_sg_addr;
   logic [1:0]          r_sel;
   logic [255:0]        r_rdata;
   logic [62:0]         r_fisig;

   logic [62:0]         w_fisig_sel;
   logic [10:0]         w_e;
   logic [71:0]         w_m;
   logic [71:0]         w_isig;
   logic                w_range_err;
   logic [72:0]         w_sigma_min;
   logic                w_unused;

   assign w_fisig_sel = r_rdata[{r_sel, 6'd0} +: 63];
   assign w_e         = r_fisig[62:52];
   assign w_m         = {19'b0, 1'b1, r_fisig[51:0]};
   assign w_sigma_min = r_mode ? MIN_SIGMA_1024 : MIN_SIGMA_512;
   assign w_unused    = ^{mul_out_l[80:72], mul_out_l[0], mul_out_r[80:72], mul_out_r[8:0],
                          3'(MUL_LAT)};

   // Double to unsigned fixed point value*2^72; sign is dropped
   always_comb begin
      w_isig      = '0;
      w_range_err = 1'b0;
      if (w_e >= 11'd1023) begin
         w_isig      = '1;
         w_range_err = 1'b1;
      end else if (w_e >= 11'd1003) begin
         w_isig = w_m << (w_e - 11'd1003);
      end else if (w_e >= 11'd951) begin
         w_isig = w_m >> (11'd1003 - w_e);
      end else begin
         w_range_err = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= StIdle;
         r_cnt       <= '0;
         r_mode      <= 1'b0;
         r_sg_addr   <= '0;
         r_sel       <= '0;
         r_rdata     <= '0;
         r_fisig     <= '0;
         busy        <= 1'b0;
         r_en        <= 1'b0;
         r_addr      <= '0;
         mul_req     <= 1'b0;
         mul_a_l     <= '0;
         mul_b_l     <= '0;
         mul_a_r     <= '0;
         mul_b_r     <= '0;
         fpr_mu      <= '0;
         isigma      <= '0;
         sqr2_isigma <= '0;
         ccs_63      <= '0;
         err         <= 1'b0;
         done        <= 1'b0;
      end else begin
         r_rdata <= r_data;
         done    <= 1'b0;
         case (r_state)
            StIdle: begin
               if (start && !busy) begin
                  busy      <= 1'b1;
                  err       <= 1'b0;
                  r_mode    <= mode;
                  r_sg_addr <= isigma_addr;
                  r_sel     <= isigma_sel;
                  r_en      <= 1'b1;
                  r_addr    <= mu_addr;
                  r_state   <= StRdMu;
               end
            end
            StRdMu: begin
               r_addr  <= r_sg_addr;
               r_cnt   <= 4'd1;
               r_state <= StRdSg;
            end
            StRdSg: begin
               r_en    <= 1'b0;
               r_addr  <= '0;
               r_cnt   <= r_cnt + 4'd1;
               r_state <= StWait;
            end
            StWait: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt == MuTap) begin
                  fpr_mu <= r_rdata[64*LANES-1:0];
               end
               if (r_cnt == FsTap) begin
                  r_fisig <= w_fisig_sel;
                  r_state <= StConv;
               end
            end
            StConv: begin
               isigma  <= w_isig;
               err     <= w_range_err;
               mul_req <= 1'b1;
               mul_a_l <= {9'b0, w_isig};
               mul_b_l <= {9'b0, w_isig};
               mul_a_r <= {9'b0, w_isig};
               mul_b_r <= {8'b0, w_sigma_min};
               r_state <= StMreq;
            end
            StMreq: begin
               if (mul_gnt) begin
                  mul_req <= 1'b0;
                  mul_a_l <= '0;
                  mul_b_l <= '0;
                  mul_a_r <= '0;
                  mul_b_r <= '0;
                  r_state <= StMwait;
               end
            end
            StMwait: begin
               if (mul_vld) begin
                  sqr2_isigma <= {1'b0, mul_out_l[71:1]};
                  ccs_63      <= mul_out_r[71:9];
                  done        <= 1'b1;
                  r_state     <= StDone;
               end
            end
            StDone: begin
               busy    <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_pre_samp_mlane.sv
// Self-checking bench for pre_samp_mlane: memory and multiplier models plus an
// arithmetic reference for the isigma conversion and both products.
module tb_pre_samp_mlane;

   localparam int unsigned LANES  = 4;
   localparam int unsigned ADDR_W = 10;
   localparam int unsigned RD     = 2;
   localparam int unsigned ML     = 1;
   localparam logic [72:0] MIN512  = 73'h147201bf1f7a0000000;
   localparam logic [72:0] MIN1024 = 73'h14c5c19990c80000000;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                mode = 1'b0;
   logic [ADDR_W-1:0]   mu_addr = '0;
   logic [ADDR_W-1:0]   isigma_addr = '0;
   logic [1:0]          isigma_sel = '0;
   logic                busy;
   logic                r_en;
   logic [ADDR_W-1:0]   r_addr;
   logic [255:0]        r_data;
   logic                mul_req;
   logic                mul_gnt = 1'b0;
   logic [80:0]         mul_a_l, mul_b_l, mul_a_r, mul_b_r;
   logic                mul_vld;
   logic [80:0]         mul_out_l, mul_out_r;
   logic [64*LANES-1:0] fpr_mu;
   logic [71:0]         isigma;
   logic [71:0]         sqr2_isigma;
   logic [62:0]         ccs_63;
   logic                err;
   logic                done;

   pre_samp_mlane #(
      .LANES(LANES), .ADDR_W(ADDR_W), .READ_DELAY(RD), .MUL_LAT(ML),
      .MIN_SIGMA_512(MIN512), .MIN_SIGMA_1024(MIN1024)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .mu_addr(mu_addr),
      .isigma_addr(isigma_addr), .isigma_sel(isigma_sel), .busy(busy), .r_en(r_en),
      .r_addr(r_addr), .r_data(r_data), .mul_req(mul_req), .mul_gnt(mul_gnt),
      .mul_a_l(mul_a_l), .mul_b_l(mul_b_l), .mul_a_r(mul_a_r), .mul_b_r(mul_b_r),
      .mul_vld(mul_vld), .mul_out_l(mul_out_l), .mul_out_r(mul_out_r), .fpr_mu(fpr_mu),
      .isigma(isigma), .sqr2_isigma(sqr2_isigma), .ccs_63(ccs_63), .err(err), .done(done)
   );

   always #5 clk = ~clk;

   // Memory with RD-cycle read latency; junk when no read is returning
   logic [255:0]      mem [1024];
   logic [RD-1:0]     pe = '0;
   logic [ADDR_W-1:0] pa [RD];
   always @(posedge clk) begin
      for (int i = RD - 1; i > 0; i--) begin
         pe[i] <= pe[i-1];
         pa[i] <= pa[i-1];
      end
      pe[0] <= r_en;
      pa[0] <= r_addr;
   end
   assign r_data = pe[RD-1] ? mem[pa[RD-1]] : {8{32'hDEADBEEF}};

   function automatic logic [80:0] mulq(input logic [80:0] a, input logic [80:0] b);
      logic [161:0] t;
      t = {81'b0, a} * {81'b0, b};
      return t[152:72];
   endfunction

   logic [80:0] prod_l = '0, prod_r = '0;
   logic [3:0]  mcnt = '0;
   logic        spur_vld = 1'b0;
   logic [80:0] spur_val = '0;
   always @(posedge clk) begin
      if (mul_req && mul_gnt) begin
         prod_l <= mulq(mul_a_l, mul_b_l);
         prod_r <= mulq(mul_a_r, mul_b_r);
         mcnt   <= 4'(ML);
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 4'd1;
      end
   end
   assign mul_vld   = (mcnt == 4'd1) || spur_vld;
   assign mul_out_l = spur_vld ? spur_val : prod_l;
   assign mul_out_r = spur_vld ? ~spur_val : prod_r;

   int n_chk = 0, n_pass = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Reference: floor(|x| * 2^72), saturating at >= 1.0, flagged outside [2^-72, 1)
   function automatic logic [71:0] ref_isig(input logic [63:0] d, output logic e_flag);
      int           e, sh;
      logic [127:0] m;
      e = int'(d[62:52]);
      m = {75'b0, 1'b1, d[51:0]};
      sh = e - 1003;
      m = (sh >= 0) ? (m << sh) : (m >> (-sh));
      e_flag = (e >= 1023) || (e < 951);
      return (e >= 1023) ? '1 : m[71:0];
   endfunction

   function automatic logic [255:0] rand256();
      logic [255:0] w;
      for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
      return w;
   endfunction

   logic [71:0]  e_isig = '0, e_sqr2 = '0;
   logic [62:0]  e_ccs = '0;
   logic         e_err = 1'b0;
   logic [255:0] e_mu = '0;

   task automatic run_job(input logic [ADDR_W-1:0] ma, input logic [ADDR_W-1:0] sa,
                          input logic [1:0] sel, input logic md, input logic [63:0] fsig,
                          input int stall, input bit mid_start);
      logic [255:0] sgw;
      logic [159:0] p;
      logic [72:0]  smin;
      int           cnt, stalls;
      bit           got;
      e_mu = rand256();
      sgw = rand256();
      sgw[64*sel +: 64] = fsig;
      mem[ma] = e_mu;
      mem[sa] = sgw;
      smin = md ? MIN1024 : MIN512;
      e_isig = ref_isig(fsig, e_err);
      p = {88'b0, e_isig} * {88'b0, e_isig};
      e_sqr2 = 72'(p >> 73);
      p = {88'b0, e_isig} * {87'b0, smin};
      e_ccs = 63'(p >> 81);
      @(posedge clk); #1;
      start = 1'b1; mode = md; mu_addr = ma; isigma_addr = sa; isigma_sel = sel;
      cnt = 0; stalls = 0; got = 1'b0;
      while (!got && cnt < 60) begin
         @(posedge clk); #1;
         start = 1'b0;
         cnt++;
         if (cnt == 1) begin
            mode = ~md; mu_addr = ~ma; isigma_sel = ~sel;
            chk("rd_mu", {busy, r_en, r_addr}, {2'b11, ma});
         end
         if (cnt == 2) chk("rd_sg", {busy, r_en, r_addr}, {2'b11, sa});
         if (cnt == 3) begin
            chk("rd_idle", {r_en, r_addr, mul_req, mul_a_l, mul_b_r}, '0);
            if (mid_start) begin
               start = 1'b1; mode = $urandom; mu_addr = 10'($urandom); isigma_sel = 2'($urandom);
            end
         end
         mul_gnt = mul_req && (stalls >= stall);
         if (mul_req) begin
            chk("operands", {mul_a_l, mul_b_l, mul_a_r, mul_b_r},
                {9'b0, e_isig, 9'b0, e_isig, 9'b0, e_isig, 8'b0, smin});
            if (!mul_gnt) stalls++;
         end
         if (done) got = 1'b1;
      end
      mul_gnt = 1'b0;
      chk("done_seen", 512'(got), 512'(1));
      chk("latency", 512'(cnt), 512'(RD + ML + 6 + stall));
      chk("isigma", {err, isigma}, {e_err, e_isig});
      chk("products", {sqr2_isigma, ccs_63}, {e_sqr2, e_ccs});
      chk("fpr_mu", fpr_mu, e_mu);
      start = 1'b1;  // lands in the DONE cycle, must be dropped
      @(posedge clk); #1;
      start = 1'b0;
      chk("after_done", {busy, done, r_en}, 3'b000);
   endtask

   task automatic quiet_check(input string tag, input int cycles);
      int n_done = 0, n_busy = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         if (done) n_done++;
         if (busy) n_busy++;
      end
      chk(tag, {32'(n_done), 32'(n_busy)}, '0);
   endtask

   initial begin
      logic [71:0]  lit;
      logic [72:0]  s;
      logic [63:0]  f;
      logic [ADDR_W-1:0] a;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outs", {done, busy, err, r_en, r_addr, mul_req, isigma, sqr2_isigma, ccs_63,
                         fpr_mu}, '0);
      rst = 1'b0;

      // isigma = 0.5, mode 1, immediate grant
      run_job(10'd5, 10'd9, 2'd0, 1'b1, 64'h3FE0000000000000, 0, 1'b0);
      chk("half_isig", {err, isigma}, {1'b0, 72'h800000000000000000});
      chk("half_sqr2", sqr2_isigma, 72'h200000000000000000);
      lit = 72'hA62E0CCC8640000000;
      chk("half_ccs1024", ccs_63, lit[71:9]);

      // top slot selection
      run_job(10'd100, 10'd200, 2'd3, 1'b0, 64'h3FD5555555555555, 0, 1'b0);
      // grant stalled 5 cycles
      run_job(10'd300, 10'd301, 2'd1, 1'b1, 64'h3FC8000000000000, 5, 1'b0);
      // exponent range edges, then a clean job clears err
      run_job(10'd7, 10'd8, 2'd2, 1'b0, 64'h3FF0000000000000, 0, 1'b0);
      chk("sat", {err, isigma}, {1'b1, {72{1'b1}}});
      run_job(10'd7, 10'd8, 2'd1, 1'b1, 64'h3B00000000000000, 0, 1'b0);
      chk("under", {err, isigma}, {1'b1, 72'h0});
      run_job(10'd11, 10'd12, 2'd0, 1'b0, 64'hBFE8000000000000, 1, 1'b0);
      chk("err_clear", err, 1'b0);

      // start while busy dropped, no extra done
      run_job(10'd20, 10'd21, 2'd2, 1'b1, 64'h3FB999999999999A, 2, 1'b1);
      quiet_check("no_second_done", 15);

      // spurious mul_vld in IDLE
      spur_val = {17'($urandom), $urandom, $urandom};
      spur_vld = 1'b1;
      @(posedge clk); #1;
      spur_vld = 1'b0;
      @(posedge clk); #1;
      chk("spurious_vld", {isigma, sqr2_isigma, ccs_63, err, fpr_mu, done, busy},
          {e_isig, e_sqr2, e_ccs, e_err, e_mu, 2'b00});

      // reset in WAIT aborts the job
      mem[10'd40] = rand256();
      mem[10'd41] = rand256();
      @(posedge clk); #1;
      start = 1'b1; mu_addr = 10'd40; isigma_addr = 10'd41; isigma_sel = 2'd0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_wait_outs", {done, busy, err, r_en, r_addr, mul_req, isigma, sqr2_isigma,
                            ccs_63, fpr_mu}, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      quiet_check("rst_no_done", 15);
      run_job(10'd50, 10'd60, 2'd3, 1'b1, 64'h3FE0000000000000, 0, 1'b0);

      // mode 0 with isigma = 0.5
      run_job(10'd70, 10'd71, 2'd1, 1'b0, 64'h3FE0000000000000, 0, 1'b0);
      s = MIN512 >> 1;
      chk("half_ccs512", ccs_63, s[71:9]);

      // random jobs
      for (int k = 0; k < 20; k++) begin
         f = {1'($urandom), 11'($urandom_range(945, 1030)), 20'($urandom), $urandom};
         a = 10'($urandom);
         run_job(a, a + 10'($urandom_range(1, 500)), 2'($urandom), 1'($urandom), f,
                 int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
